// File: rtl/mem_arb_pkg.sv
// Shared types for mem_port_arbiter: access-size encodings, FSM states and
// requester identities.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/lane_align.sv
// lane_align: combinational store byte-enable/data replication and load lane
// extraction with sign or zero extension. Also flags misaligned/illegal sizes.
module lane_align
  import mem_arb_pkg::*;
(
  input  size_e       st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_mask,
  output logic [31:0] st_data,
  output logic        st_misaligned,
  input  size_e       ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    st_mask       = 4'b0000;
    st_data       = st_wdata;
    st_misaligned = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        st_mask = 4'b0001 << st_addr_lo;
        st_data = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_mask       = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_data       = {2{st_wdata[15:0]}};
        st_misaligned = st_addr_lo[0];
      end
      SZ_WORD: begin
        st_mask       = 4'b1111;
        st_misaligned = |st_addr_lo;
      end
      default: st_misaligned = 1'b1;
    endcase
  end

  assign ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
  assign ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  always_comb begin
    ld_data = '0;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
      SZ_HALF: ld_data = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
      SZ_WORD: ld_data = ld_rdata;
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port BRAM between fetch (IF) and load/store (LS).
// Define ARB_ROUND_ROBIN_EN to alternate grants when both requesters are valid.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AWIDTH  = 14,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [31:0]       if_req_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_req_we,
  input  logic [31:0]       ls_req_addr,
  input  logic [31:0]       ls_req_wdata,
  input  logic [1:0]        ls_req_size,
  input  logic              ls_req_unsigned,
  output logic              ls_resp_valid,
  output logic [31:0]       ls_resp_data,
  output logic              err_misaligned,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_e        state_q, state_d;
  owner_e        grant, owner_q;
  logic [CW-1:0] lat_cnt_q;
  size_e         size_q;
  logic [1:0]    lo_q;
  logic          uns_q, we_q, err_q;
  logic          hs, if_err, ls_err, last_cnt;
  size_e         ls_size;
  logic [3:0]    st_mask;
  logic [31:0]   st_data, ld_data;
  logic          unused_addr_bits;

  assign ls_size  = size_e'(ls_req_size);
  assign if_err   = |if_req_addr[1:0];
  assign last_cnt = (lat_cnt_q == CW'(MEM_LAT - 1));
  assign unused_addr_bits = ^{if_req_addr[31:AWIDTH+2], ls_req_addr[31:AWIDTH+2]};

  lane_align u_lane_align (
    .st_size      (ls_size),
    .st_addr_lo   (ls_req_addr[1:0]),
    .st_wdata     (ls_req_wdata),
    .st_mask      (st_mask),
    .st_data      (st_data),
    .st_misaligned(ls_err),
    .ld_size      (size_q),
    .ld_addr_lo   (lo_q),
    .ld_unsigned  (uns_q),
    .ld_rdata     (mem_dout),
    .ld_data      (ld_data)
  );

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_grant_q;

  always_comb begin
    if (if_req_valid && ls_req_valid) grant = (last_grant_q == OWN_LS) ? OWN_IF : OWN_LS;
    else                              grant = ls_req_valid ? OWN_LS : OWN_IF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  last_grant_q <= OWN_IF;
    else if (hs) last_grant_q <= grant;
  end
`else
  assign grant = ls_req_valid ? OWN_LS : OWN_IF;
`endif

  // The BRAM port is driven combinationally in the handshake cycle only.
  always_comb begin
    state_d      = state_q;
    if_req_ready = 1'b0;
    ls_req_ready = 1'b0;
    hs           = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 4'b0000;
    mem_addr     = '0;
    mem_din      = '0;
    case (state_q)
      IDLE: begin
        if (rst_n && grant == OWN_LS && ls_req_valid) begin
          ls_req_ready = 1'b1;
          hs           = 1'b1;
          mem_en       = ~ls_err;
          mem_we       = (ls_req_we && !ls_err) ? st_mask : 4'b0000;
          mem_addr     = ls_req_addr[AWIDTH+1:2];
          mem_din      = ls_req_we ? st_data : '0;
        end else if (rst_n && grant == OWN_IF && if_req_valid) begin
          if_req_ready = 1'b1;
          hs           = 1'b1;
          mem_en       = ~if_err;
          mem_addr     = if_req_addr[AWIDTH+1:2];
        end
        if (hs) state_d = WAIT;
      end
      WAIT:    if (last_cnt) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lat_cnt_q      <= '0;
      owner_q        <= OWN_IF;
      size_q         <= SZ_WORD;
      lo_q           <= 2'b00;
      uns_q          <= 1'b0;
      we_q           <= 1'b0;
      err_q          <= 1'b0;
      if_resp_valid  <= 1'b0;
      if_resp_data   <= '0;
      ls_resp_valid  <= 1'b0;
      ls_resp_data   <= '0;
      err_misaligned <= 1'b0;
    end else begin
      state_q        <= state_d;
      if_resp_valid  <= 1'b0;
      ls_resp_valid  <= 1'b0;
      err_misaligned <= 1'b0;
      if (hs) begin
        lat_cnt_q <= '0;
        owner_q   <= grant;
        size_q    <= ls_size;
        lo_q      <= ls_req_addr[1:0];
        uns_q     <= ls_req_unsigned;
        we_q      <= ls_req_we;
        err_q     <= (grant == OWN_LS) ? ls_err : if_err;
      end else if (state_q == WAIT) begin
        lat_cnt_q <= lat_cnt_q + 1'b1;
        if (last_cnt) begin
          err_misaligned <= err_q;
          if (owner_q == OWN_LS) begin
            ls_resp_valid <= 1'b1;
            ls_resp_data  <= (err_q || we_q) ? '0 : ld_data;
          end else begin
            if_resp_valid <= 1'b1;
            if_resp_data  <= err_q ? '0 : mem_dout;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MEM_LAT = 1) with a
// one-cycle BRAM model. Honours ARB_ROUND_ROBIN_EN for the arbitration scenario.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [31:0] if_req_addr, if_resp_data;
  logic        ls_req_valid, ls_req_ready, ls_req_we, ls_req_unsigned, ls_resp_valid;
  logic [31:0] ls_req_addr, ls_req_wdata, ls_resp_data;
  logic [1:0]  ls_req_size;
  logic        err_misaligned, mem_en;
  logic [3:0]  mem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din, mem_dout;

  int checks = 0;
  int errors = 0;

  logic        o_rdy, o_en, o_early, o_at, o_late, o_err;
  logic [3:0]  o_we;
  logic [13:0] o_addr;
  logic [31:0] o_din, o_data;

  logic [31:0] mem_arr [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr;
  logic [31:0] pl_data;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AWIDTH(14), .MEM_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_size(ls_req_size),
    .ls_req_unsigned(ls_req_unsigned), .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
    .err_misaligned(err_misaligned), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // BRAM model: one-cycle read latency, read-before-write, plus a preload port.
  always @(posedge clk) begin
    if (pl_en) mem_arr[pl_addr] <= pl_data;
    else if (mem_en) begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem_arr[mem_addr[3:0]][8*i +: 8] <= mem_din[8*i +: 8];
      mem_dout <= mem_arr[mem_addr[3:0]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic ls_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns);
    @(negedge clk);
    ls_req_valid = 1'b1; ls_req_we = we; ls_req_addr = addr;
    ls_req_wdata = wdata; ls_req_size = size; ls_req_unsigned = uns;
    #1;
    o_rdy = ls_req_ready; o_en = mem_en; o_we = mem_we; o_addr = mem_addr; o_din = mem_din;
    @(posedge clk);
    @(negedge clk);
    ls_req_valid = 1'b0;
    o_early = ls_resp_valid;
    @(negedge clk);
    o_at = ls_resp_valid; o_data = ls_resp_data; o_err = err_misaligned;
    @(negedge clk);
    o_late = ls_resp_valid;
  endtask

  task automatic if_xfer(input logic [31:0] addr);
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = addr;
    #1;
    o_rdy = if_req_ready; o_en = mem_en; o_we = mem_we; o_addr = mem_addr; o_din = mem_din;
    @(posedge clk);
    @(negedge clk);
    if_req_valid = 1'b0;
    o_early = if_resp_valid;
    @(negedge clk);
    o_at = if_resp_valid; o_data = if_resp_data; o_err = err_misaligned;
    @(negedge clk);
    o_late = if_resp_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 32'h0;
    ls_req_valid = 1'b1; ls_req_we = 1'b1; ls_req_addr = 32'h10;
    ls_req_wdata = 32'hFFFF_FFFF; ls_req_size = SZ_WORD; ls_req_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({if_req_ready, ls_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {if_req_ready, ls_req_ready}); end
    checks++; if ({mem_en, mem_we, mem_addr, mem_din} !== '0) begin errors++; $display("FAIL reset_mem: got en=%b we=%b addr=%h din=%h expected all 0", mem_en, mem_we, mem_addr, mem_din); end
    checks++; if ({if_resp_valid, ls_resp_valid, err_misaligned, if_resp_data, ls_resp_data} !== '0) begin errors++; $display("FAIL reset_resp: got ifv=%b lsv=%b err=%b ifd=%h lsd=%h expected all 0", if_resp_valid, ls_resp_valid, err_misaligned, if_resp_data, ls_resp_data); end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    preload(4'd0, 32'h0050_0093);
    preload(4'd4, 32'h8899_AABB);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    owner_e exp_own [3];
    owner_e got;
    logic   found, both;
`ifdef ARB_ROUND_ROBIN_EN
    exp_own = '{OWN_LS, OWN_IF, OWN_LS};
`else
    exp_own = '{OWN_LS, OWN_LS, OWN_LS};
`endif
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 32'h0;
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h10; ls_req_size = SZ_WORD; ls_req_unsigned = 1'b0;
    for (int g = 0; g < 3; g++) begin
      found = 1'b0; both = 1'b0; got = OWN_IF;
      for (int c = 0; c < 8 && !found; c++) begin
        #1;
        if (if_req_ready || ls_req_ready) begin
          found = 1'b1;
          both  = if_req_ready && ls_req_ready;
          got   = ls_req_ready ? OWN_LS : OWN_IF;
        end
        @(negedge clk);
      end
      checks++; if (!found || got !== exp_own[g]) begin errors++; $display("FAIL arb_grant%0d: got found=%b owner=%s expected owner=%s", g, found, got.name(), exp_own[g].name()); end
      checks++; if (both !== 1'b0) begin errors++; $display("FAIL arb_exclusive%0d: got both_ready=%b expected 0", g, both); end
    end
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_load_word();
    ls_xfer(1'b0, 32'h0000_0010, 32'h0, SZ_WORD, 1'b0);
    checks++; if ({o_rdy, o_en, o_we} !== 6'b11_0000) begin errors++; $display("FAIL lw_port: got rdy=%b en=%b we=%b expected 1 1 0000", o_rdy, o_en, o_we); end
    checks++; if (o_addr !== 14'd4) begin errors++; $display("FAIL lw_addr: got %0d expected 4", o_addr); end
    checks++; if ({o_early, o_at, o_late} !== 3'b010) begin errors++; $display("FAIL lw_timing: got T+1/T+2/T+3=%b expected 010", {o_early, o_at, o_late}); end
    checks++; if (o_data !== 32'h8899_AABB || o_err !== 1'b0) begin errors++; $display("FAIL lw_data: got %h err=%b expected 8899aabb err=0", o_data, o_err); end
    if_xfer(32'h0);
    checks++; if (o_at !== 1'b1 || o_data !== 32'h0050_0093) begin errors++; $display("FAIL if_fetch: got v=%b %h expected v=1 00500093", o_at, o_data); end
    checks++; if (ls_resp_data !== 32'h8899_AABB) begin errors++; $display("FAIL ls_hold: got %h expected 8899aabb", ls_resp_data); end
  endtask

  task automatic test_load_extend();
    preload(4'd4, 32'h80FF_0000);
    ls_xfer(1'b0, 32'h13, 32'h0, SZ_BYTE, 1'b0);
    checks++; if (o_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_sign: got %h expected ffffff80", o_data); end
    ls_xfer(1'b0, 32'h13, 32'h0, SZ_BYTE, 1'b1);
    checks++; if (o_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_zero: got %h expected 00000080", o_data); end
    ls_xfer(1'b0, 32'h12, 32'h0, SZ_HALF, 1'b0);
    checks++; if (o_data !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh_sign: got %h expected ffff80ff", o_data); end
    ls_xfer(1'b0, 32'h12, 32'h0, SZ_HALF, 1'b1);
    checks++; if (o_data !== 32'h0000_80FF) begin errors++; $display("FAIL lhu_zero: got %h expected 000080ff", o_data); end
    ls_xfer(1'b0, 32'h11, 32'h0, SZ_BYTE, 1'b0);
    checks++; if (o_data !== 32'h0000_0000) begin errors++; $display("FAIL lb_lane1: got %h expected 00000000", o_data); end
  endtask

  task automatic test_store();
    preload(4'd8, 32'hDEAD_BEEF);
    ls_xfer(1'b1, 32'h0000_0022, 32'h0000_1234, SZ_HALF, 1'b0);
    checks++; if ({o_en, o_we} !== 5'b1_1100 || o_addr !== 14'd8) begin errors++; $display("FAIL sh_port: got en=%b we=%b addr=%0d expected 1 1100 8", o_en, o_we, o_addr); end
    checks++; if (o_din !== 32'h1234_1234) begin errors++; $display("FAIL sh_din: got %h expected 12341234", o_din); end
    checks++; if (o_at !== 1'b1 || o_data !== 32'h0 || o_err !== 1'b0) begin errors++; $display("FAIL sh_ack: got v=%b %h err=%b expected v=1 00000000 err=0", o_at, o_data, o_err); end
    ls_xfer(1'b1, 32'h0000_0021, 32'hFFFF_FFA5, SZ_BYTE, 1'b0);
    checks++; if (o_we !== 4'b0010 || o_din !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_lane: got we=%b din=%h expected 0010 a5a5a5a5", o_we, o_din); end
    ls_xfer(1'b0, 32'h0000_0020, 32'h0, SZ_WORD, 1'b0);
    checks++; if (o_data !== 32'h1234_A5EF) begin errors++; $display("FAIL st_readback: got %h expected 1234a5ef", o_data); end
  endtask

  task automatic test_misaligned();
    ls_xfer(1'b0, 32'h0000_0006, 32'h0, SZ_WORD, 1'b0);
    checks++; if ({o_rdy, o_en, o_we} !== 6'b10_0000) begin errors++; $display("FAIL lw_mis_port: got rdy=%b en=%b we=%b expected 1 0 0000", o_rdy, o_en, o_we); end
    checks++; if ({o_early, o_at, o_late} !== 3'b010 || o_data !== 32'h0 || o_err !== 1'b1) begin errors++; $display("FAIL lw_mis_resp: got seq=%b %h err=%b expected 010 00000000 err=1", {o_early, o_at, o_late}, o_data, o_err); end
    ls_xfer(1'b1, 32'h0000_0021, 32'h5555_5555, SZ_WORD, 1'b0);
    checks++; if ({o_en, o_we} !== 5'b0_0000 || o_err !== 1'b1) begin errors++; $display("FAIL sw_mis: got en=%b we=%b err=%b expected 0 0000 1", o_en, o_we, o_err); end
    ls_xfer(1'b0, 32'h0000_0013, 32'h0, SZ_HALF, 1'b0);
    checks++; if (o_en !== 1'b0 || o_err !== 1'b1 || o_data !== 32'h0) begin errors++; $display("FAIL lh_mis: got en=%b err=%b %h expected 0 1 00000000", o_en, o_err, o_data); end
    ls_xfer(1'b0, 32'h0000_0010, 32'h0, 2'b11, 1'b0);
    checks++; if (o_en !== 1'b0 || o_err !== 1'b1 || o_data !== 32'h0) begin errors++; $display("FAIL size_ill: got en=%b err=%b %h expected 0 1 00000000", o_en, o_err, o_data); end
    if_xfer(32'h0000_0002);
    checks++; if (o_en !== 1'b0 || o_at !== 1'b1 || o_err !== 1'b1 || o_data !== 32'h0) begin errors++; $display("FAIL if_mis: got en=%b v=%b err=%b %h expected 0 1 1 00000000", o_en, o_at, o_err, o_data); end
  endtask

  task automatic test_back_to_back();
    logic r0, r1, r2, v1, v2;
    @(negedge clk);
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h10; ls_req_size = SZ_WORD; ls_req_unsigned = 1'b0;
    #1; r0 = ls_req_ready;
    @(negedge clk); #1; r1 = ls_req_ready; v1 = ls_resp_valid;
    @(negedge clk); #1; r2 = ls_req_ready; v2 = ls_resp_valid;
    @(negedge clk);
    ls_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({r0, r1, v1} !== 3'b100) begin errors++; $display("FAIL b2b_wait: got rdyT=%b rdyT1=%b vT1=%b expected 1 0 0", r0, r1, v1); end
    checks++; if ({r2, v2} !== 2'b11) begin errors++; $display("FAIL b2b_overlap: got rdy=%b resp=%b expected 1 1", r2, v2); end
  endtask

  task automatic test_reset_in_wait();
    logic seen;
    @(negedge clk);
    ls_req_valid = 1'b1; ls_req_we = 1'b0; ls_req_addr = 32'h10; ls_req_size = SZ_WORD; ls_req_unsigned = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ls_req_valid = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h0;
    rst_n = 1'b0;
    #1;
    checks++; if ({if_req_ready, ls_req_ready, mem_en} !== 3'b000) begin errors++; $display("FAIL rst_wait_ready: got if=%b ls=%b en=%b expected 000", if_req_ready, ls_req_ready, mem_en); end
    seen = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      seen = seen | ls_resp_valid | if_resp_valid;
    end
    if_req_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      seen = seen | ls_resp_valid | if_resp_valid;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_wait_noresp: got resp_seen=%b expected 0", seen); end
    if_xfer(32'h0);
    checks++; if ({o_rdy, o_early, o_at, o_late} !== 4'b1010 || o_data !== 32'h0050_0093) begin errors++; $display("FAIL rst_wait_fetch: got rdy/seq=%b %h expected 1010 00500093", {o_rdy, o_early, o_at, o_late}, o_data); end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_load_word();
    test_load_extend();
    test_store();
    test_misaligned();
    test_back_to_back();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port data/instruction BRAM between the fetch stage (IF) and the load/store stage (LS) of the RISC-V core. Arbitrates requests, drives the BRAM port, generates store byte-enables and lane-shifted write data, and returns sign- or zero-extended load data. Sits between the pipeline and the memory macro, replacing per-stage ad hoc memory muxing and post-memory load extraction.

## Interface
- AWIDTH, 14: BRAM word-address width; byte address bits [AWIDTH+1:2] select the word.
- MEM_LAT, 1: BRAM read latency in cycles (≥1).
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req_valid / if_req_ready  in / out  1  IF request handshake.
- if_req_addr  in  32  fetch byte address; word-aligned only.
- if_resp_valid  out  1  one-cycle pulse, fetch data valid.
- if_resp_data  out  32  fetched instruction.
- ls_req_valid / ls_req_ready  in / out  1  LS request handshake.
- ls_req_we  in  1  1 = store, 0 = load.
- ls_req_addr  in  32  byte address.
- ls_req_wdata  in  32  store data, right-justified.
- ls_req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- ls_req_unsigned  in  1  zero-extend load (lbu/lhu).
- ls_resp_valid  out  1  one-cycle pulse, load data / store ack.
- ls_resp_data  out  32  extended load data; 0 for stores and errors.
- err_misaligned  out  1  pulse with a resp_valid whose request was misaligned/illegal.
- mem_en  out  1  BRAM enable.
- mem_we  out  4  BRAM byte write enables.
- mem_addr  out  AWIDTH  BRAM word address.
- mem_din  out  32  BRAM write data.
- mem_dout  in  32  BRAM read data, valid MEM_LAT cycles after mem_en.

## Operation
- FSM states: IDLE, WAIT. Reset → IDLE.
- IDLE: grant one pending requester; its req_ready = 1 combinationally, all other readies 0. On handshake (cycle T): drive mem_en/mem_addr/mem_we/mem_din combinationally that cycle, latch owner, size, unsigned, addr[1:0], error flag; go to WAIT.
- WAIT: count MEM_LAT cycles; at the final WAIT cycle register mem_dout through lane extraction into resp_data; go to IDLE. Readies are 0 in WAIT.
- Default arbitration: LS wins whenever both valid (fixed priority).
- Store lanes: byte → mem_we = 0001 << addr[1:0], data replicated to all four bytes; half → 0011 or 1100, data replicated to both halves; word → 1111.
- Load extraction: select byte lane addr[1:0] or half lane addr[1]; extend per ls_req_unsigned. IF data passes unmodified.
- Misaligned (half with addr[0]=1, word with addr[1:0]≠0, IF addr[1:0]≠0) or size 11: request still accepted, mem_en = 0, mem_we = 0; response pulses on normal schedule with data 0 and err_misaligned = 1.
- Store response: ls_resp_valid pulses, ls_resp_data = 0.

## Timing
- Reset: state IDLE, all resp_valid, resp_data, err_misaligned, mem_en, mem_we, mem_addr, mem_din = 0; both readies 0 while rst_n low. In-flight response discarded.
- Latency: handshake at T → resp_valid high at T+MEM_LAT+1 for exactly one cycle.
- Throughput: one request per MEM_LAT+1 cycles; a new request may hand-shake in the same cycle resp_valid is high.
- resp_data holds its value until the next response of the same owner.
- valid may drop without handshake; no request is remembered.
- Reset asserted in WAIT: immediate return to IDLE, no response.

## Configuration
- ARB_ROUND_ROBIN_EN defined: one-bit last-grant register (reset = IF); when both valid in IDLE, grant the requester not granted last; a lone requester is always granted.
- Undefined: fixed LS priority, no last-grant register.

## Structure
- Package mem_arb_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state typedef, owner enum (OWN_IF, OWN_LS).
- Sub-module lane_align: combinational store mask/data generation and load extraction/extension; the arbiter instantiates it once.

## Test plan
- LS load word 0x0000_0010, mem word 0x8899_AABB, MEM_LAT=1 → handshake T, ls_resp_valid at T+2, data 0x8899_AABB.
- LS lb at 0x13 then lbu at 0x13 on word 0x80FF_0000 → 0xFFFF_FF80, then 0x0000_0080.
- LS sh 0x1234 at 0x0000_0022 → mem_we = 1100, mem_din = 0x1234_1234, mem_addr = 8; ack with data 0.
- LS lw at 0x0000_0006 → mem_en = 0, resp data 0, err_misaligned = 1 at T+2.
- Both valid three consecutive grants → fixed: LS,LS,LS; with ARB_ROUND_ROBIN_EN: LS,IF,LS.
- rst_n low during WAIT → no resp_valid; after release, IF fetch at 0x0 returns mem word at T+2.
